// File: rtl/branch_resolve_queue_if.sv
// Fetch/decode handshake bundle for branch_resolve_queue: push side, resolve side,
// predictor update and recovery outputs.
interface branch_resolve_queue_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned HIST_WIDTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  push_valid;
  logic                  push_ready;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic                  push_pred;
  logic [HIST_WIDTH-1:0] push_hist;
  logic                  res_valid;
  logic                  res_is_branch;
  logic                  res_taken;
  logic                  upd_we;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic                  upd_pred;
  logic                  upd_correct;
  logic                  mispredict;
  logic [HIST_WIDTH-1:0] recover_hist;
  logic [CNT_W-1:0]      count;
  logic                  res_err;

  // Fetch/decode side (drives pushes and resolves)
  modport master (
    output push_valid, push_pc, push_pred, push_hist,
    output res_valid, res_is_branch, res_taken,
    input  push_ready, upd_we, upd_pc, upd_pred, upd_correct,
    input  mispredict, recover_hist, count, res_err
  );

  // Queue side
  modport slave (
    input  push_valid, push_pc, push_pred, push_hist,
    input  res_valid, res_is_branch, res_taken,
    output push_ready, upd_we, upd_pc, upd_pred, upd_correct,
    output mispredict, recover_hist, count, res_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue: issues predictor updates and mispredict recovery.
// Optional BRQ_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned HIST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_queue_if.slave bus
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic [HIST_WIDTH-1:0] hist;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  entry_t head_c;
  logic   res_fire_c;
  logic   push_fire_c;
  logic   outcome_c;
  logic   mispred_c;

  assign bus.push_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign bus.count      = count_q;

  // Head-of-queue decode for this cycle's resolve
  always_comb begin
    head_c      = mem[rd_ptr];
    res_fire_c  = bus.res_valid && (count_q != '0);
    push_fire_c = bus.push_valid && bus.push_ready;
    outcome_c   = bus.res_is_branch && bus.res_taken;
    mispred_c   = res_fire_c && (head_c.pred != outcome_c);
  end

  // Entry storage; wrong-path pushes are dropped on a mispredict
  always_ff @(posedge clk) begin
    if (!rst && push_fire_c && !mispred_c) begin
      mem[wr_ptr] <= '{pc: bus.push_pc, pred: bus.push_pred, hist: bus.push_hist};
    end
  end

  // Pointers, occupancy and registered update/recovery outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count_q          <= '0;
      bus.upd_we       <= 1'b0;
      bus.upd_pc       <= '0;
      bus.upd_pred     <= 1'b0;
      bus.upd_correct  <= 1'b0;
      bus.mispredict   <= 1'b0;
      bus.recover_hist <= '0;
      bus.res_err      <= 1'b0;
    end else begin
      bus.upd_we     <= res_fire_c && bus.res_is_branch;
      bus.mispredict <= mispred_c;

      if (bus.res_valid && (count_q == '0)) begin
        bus.res_err <= 1'b1;
      end

      if (res_fire_c && bus.res_is_branch) begin
        bus.upd_pc      <= head_c.pc;
        bus.upd_pred    <= head_c.pred;
        bus.upd_correct <= !mispred_c;
      end

      if (mispred_c) begin
        bus.recover_hist <= {head_c.hist[HIST_WIDTH-2:0], outcome_c};
        rd_ptr           <= rd_ptr + PTR_W'(1);
        wr_ptr           <= rd_ptr + PTR_W'(1);
        count_q          <= '0;
      end else begin
        if (res_fire_c) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push_fire_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push_fire_c) - CNT_W'(res_fire_c);
      end
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating event counters aligned with the upd_we / mispredict strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_fire_c && bus.res_is_branch && (stat_branches != '1)) begin
        stat_branches <= stat_branches + 32'(1);
      end
      if (mispred_c && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 26;
  localparam int unsigned HW    = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
    logic [HW-1:0] hist;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) bus ();

`ifdef BRQ_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));
`else
  branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of outstanding predictions
  ent_t          q[$];
  logic          m_we, m_pred, m_correct, m_misp, m_err;
  logic [AW-1:0] m_pc;
  logic [HW-1:0] m_rh;
  logic [31:0]   m_sb, m_sm;
  bit            started = 0;
  ent_t          e_tmp;
  logic          o_tmp, pf_tmp;

  always @(posedge clk) begin
    started <= 1;
    if (rst) begin
      q.delete();
      m_we = 0; m_pc = '0; m_pred = 0; m_correct = 0; m_misp = 0; m_rh = '0; m_err = 0;
      m_sb = '0; m_sm = '0;
    end else begin
      pf_tmp = bus.push_valid && (q.size() < DEPTH);
      m_we = 0;
      m_misp = 0;
      if (bus.res_valid && q.size() == 0) m_err = 1;
      if (bus.res_valid && q.size() > 0) begin
        e_tmp = q.pop_front();
        o_tmp = bus.res_is_branch ? bus.res_taken : 1'b0;
        if (bus.res_is_branch) begin
          m_we = 1; m_pc = e_tmp.pc; m_pred = e_tmp.pred; m_correct = (e_tmp.pred == o_tmp);
          if (m_sb != 32'hFFFF_FFFF) m_sb++;
        end
        if (e_tmp.pred != o_tmp) begin
          m_misp = 1;
          m_rh = {e_tmp.hist[HW-2:0], o_tmp};
          q.delete();
          pf_tmp = 0;
          if (m_sm != 32'hFFFF_FFFF) m_sm++;
        end
      end
      if (pf_tmp) q.push_back('{pc: bus.push_pc, pred: bus.push_pred, hist: bus.push_hist});
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("push_ready", 64'(bus.push_ready), 64'(!rst && q.size() < DEPTH));
      chk("count", 64'(bus.count), 64'(q.size()));
      chk("res_err", 64'(bus.res_err), 64'(m_err));
      chk("upd_we", 64'(bus.upd_we), 64'(m_we));
      chk("upd_pc", 64'(bus.upd_pc), 64'(m_pc));
      chk("upd_pred", 64'(bus.upd_pred), 64'(m_pred));
      chk("upd_correct", 64'(bus.upd_correct), 64'(m_correct));
      chk("mispredict", 64'(bus.mispredict), 64'(m_misp));
      chk("recover_hist", 64'(bus.recover_hist), 64'(m_rh));
`ifdef BRQ_STATS_EN
      chk("stat_branches", 64'(stat_branches), 64'(m_sb));
      chk("stat_mispredicts", 64'(stat_mispredicts), 64'(m_sm));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    bus.push_valid = 0; bus.push_pc = '0; bus.push_pred = 0; bus.push_hist = '0;
    bus.res_valid = 0; bus.res_is_branch = 0; bus.res_taken = 0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic pred, input logic [HW-1:0] hist);
    bus.push_valid = 1; bus.push_pc = pc; bus.push_pred = pred; bus.push_hist = hist;
  endtask

  task automatic resolve(input logic br, input logic tk);
    bus.res_valid = 1; bus.res_is_branch = br; bus.res_taken = tk;
  endtask

`ifdef BRQ_STATS_EN
  logic [31:0] sb_base;
`endif

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ready", 64'(bus.push_ready), 64'd0);
    rst = 0;

    // Fill to full; the fifth push is refused
    for (int i = 0; i < 4; i++) begin
      push(AW'(32'h10 + i), 1'b1, 4'b1010);
      tick();
    end
    push(AW'(32'h14), 1'b1, 4'b1010);
    tick();
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_ready", 64'(bus.push_ready), 64'd0);
    idle();

    // Correct taken resolve of the oldest entry
    resolve(1'b1, 1'b1);
    tick();
    idle();
    chk("res_upd_we", 64'(bus.upd_we), 64'd1);
    chk("res_upd_pc", 64'(bus.upd_pc), 64'h10);
    chk("res_correct", 64'(bus.upd_correct), 64'd1);
    chk("res_misp", 64'(bus.mispredict), 64'd0);
    chk("res_count", 64'(bus.count), 64'd3);

    // Mispredict flushes, same-cycle push is discarded
    resolve(1'b1, 1'b0);
    push(AW'(32'h55), 1'b0, 4'b0000);
    tick();
    idle();
    chk("mp_misp", 64'(bus.mispredict), 64'd1);
    chk("mp_hist", 64'(bus.recover_hist), 64'b0100);
    chk("mp_count", 64'(bus.count), 64'd0);
    tick();
    chk("mp_count_after", 64'(bus.count), 64'd0);
    chk("mp_pulse", 64'(bus.mispredict), 64'd0);

    // Non-branch drops: pred=0 silent, pred=1 mispredicts with outcome 0
    push(AW'(32'h20), 1'b0, 4'b1111);
    tick();
    push(AW'(32'h21), 1'b1, 4'b0011);
    tick();
    idle();
    resolve(1'b0, 1'b1);
    tick();
    idle();
    chk("nb_we", 64'(bus.upd_we), 64'd0);
    chk("nb_misp", 64'(bus.mispredict), 64'd0);
    chk("nb_count", 64'(bus.count), 64'd1);
    resolve(1'b0, 1'b0);
    tick();
    idle();
    chk("nb1_misp", 64'(bus.mispredict), 64'd1);
    chk("nb1_hist", 64'(bus.recover_hist), 64'b0110);
    chk("nb1_count", 64'(bus.count), 64'd0);

    // Resolve on empty queue sets the sticky error; reset clears it
    resolve(1'b1, 1'b1);
    tick();
    idle();
    chk("err_set", 64'(bus.res_err), 64'd1);
    chk("err_count", 64'(bus.count), 64'd0);
    tick();
    chk("err_sticky", 64'(bus.res_err), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("err_clr", 64'(bus.res_err), 64'd0);

    // Pointer wrap with steady occupancy
    push(AW'(32'h100), 1'b1, 4'b0001);
    tick();
`ifdef BRQ_STATS_EN
    sb_base = stat_branches;
`endif
    for (int k = 0; k < 10; k++) begin
      push(AW'(32'h101 + k), 1'b1, 4'b0001);
      resolve(1'b1, 1'b1);
      tick();
      chk("wrap_count", 64'(bus.count), 64'd1);
      chk("wrap_pc", 64'(bus.upd_pc), 64'(32'h100 + k));
    end
    idle();
`ifdef BRQ_STATS_EN
    chk("wrap_stats", 64'(stat_branches - sb_base), 64'd10);
`endif
    resolve(1'b1, 1'b1);
    tick();
    idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 127) == 0);
      bus.push_valid    = ($urandom_range(0, 9) < 6);
      bus.push_pc       = AW'($urandom);
      bus.push_pred     = 1'($urandom);
      bus.push_hist     = HW'($urandom);
      bus.res_valid     = ($urandom_range(0, 9) < 5);
      bus.res_is_branch = ($urandom_range(0, 9) < 8);
      bus.res_taken     = 1'($urandom);
      tick();
    end
    rst = 0;
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
